// File: rtl/whack_if.sv
// Whack event handshake between the button encoder (master) and the scorer (slave).
`timescale 1ns/1ps
interface whack_if;
  logic       whack_valid;
  logic [2:0] whack_pos;
  logic       whack_ready;

  modport master (output whack_valid, output whack_pos, input whack_ready);
  modport slave  (input whack_valid, input whack_pos, output whack_ready);
endinterface

// File: rtl/whack_encoder.sv
// whack_encoder: synchronises and debounces five buttons, turns debounced
// rising edges into single whack events and hands them to the scorer over a
// valid/ready handshake.
// Optional feature: define WHACK_HOLDOFF_EN to add a post-acceptance lockout
// of HOLDOFF_CYCLES cycles during which presses are discarded.
//
// state | meaning
// IDLE  | no event pending, next press is captured
// PEND  | event pending, waiting for whack_ready; new presses are dropped
// HOLD  | lockout after acceptance (WHACK_HOLDOFF_EN only); presses dropped
`timescale 1ns/1ps
module whack_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLDOFF_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_raw,
  whack_if.master    wif,
  output logic       multi_press,
  output logic       drop_sticky
);

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

  state_t      state, state_n;
  logic [4:0]  sync1, sync2;
  logic [4:0]  deb, deb_d, press_q;
  logic [19:0] cnt [5];
  logic [2:0]  pos_q, pos_n;
  logic        drop_n, multi_n;

`ifdef WHACK_HOLDOFF_EN
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);
  logic [31:0] hold_cnt, hold_n;
`endif

  // Lowest-numbered button wins when several press in the same cycle.
  function automatic logic [2:0] encode(input logic [4:0] p);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (p[i]) code = 3'(i + 1);
    end
    return code;
  endfunction

  // Two-flop synchroniser on every raw button line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Per-button stability counter; level flips only after a full run of differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 20'd1;
        end
      end
    end
  end

  // Registered rising-edge detect on the debounced levels; releases are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_d   <= '0;
      press_q <= '0;
    end else begin
      deb_d   <= deb;
      press_q <= deb & ~deb_d;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pos_q       <= '0;
      drop_sticky <= 1'b0;
      multi_press <= 1'b0;
`ifdef WHACK_HOLDOFF_EN
      hold_cnt    <= '0;
`endif
    end else begin
      state       <= state_n;
      pos_q       <= pos_n;
      drop_sticky <= drop_n;
      multi_press <= multi_n;
`ifdef WHACK_HOLDOFF_EN
      hold_cnt    <= hold_n;
`endif
    end
  end

  // Next-state: capture a press in IDLE, drop presses otherwise, release on handshake.
  always_comb begin
    state_n = state;
    pos_n   = pos_q;
    drop_n  = drop_sticky;
    multi_n = (press_q & (press_q - 5'd1)) != 5'd0;
`ifdef WHACK_HOLDOFF_EN
    hold_n  = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (|press_q) begin
          state_n = PEND;
          pos_n   = encode(press_q);
        end
      end
      PEND: begin
        if (|press_q) drop_n = 1'b1;
        if (wif.whack_ready) begin
          pos_n = '0;
`ifdef WHACK_HOLDOFF_EN
          state_n = HOLD;
          hold_n  = HOLD_LAST;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef WHACK_HOLDOFF_EN
      HOLD: begin
        if (|press_q) drop_n = 1'b1;
        if (hold_cnt == '0) state_n = IDLE;
        else                hold_n  = hold_cnt - 32'd1;
      end
`endif
      default: begin
        state_n = IDLE;
        pos_n   = '0;
      end
    endcase
  end

  assign wif.whack_valid = (state == PEND);
  assign wif.whack_pos   = (state == PEND) ? pos_q : 3'd0;

endmodule

// File: tb/tb_whack_encoder.sv
// Self-checking bench for whack_encoder: directed scenarios followed by random
// button/ready traffic, all compared against a window-based reference model.
`timescale 1ns/1ps
module tb_whack_encoder;
  localparam int D = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic       multi_press, drop_sticky;

  whack_if wif();

  whack_encoder #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .wif        (wif),
    .multi_press(multi_press),
    .drop_sticky(drop_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a button's level changes once the last D synchronised
  // samples all disagree with it; a 0->1 change reaches the FSM two cycles later.
  bit         m_smp [5][D+2];
  bit         m_deb [5];
  bit         all_diff;
  logic [4:0] rise_now, rise_d1, rise_d2, pv;
  bit         e_valid, e_multi, e_drop;
  int         e_pos, hold_left, first;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 5; b++) begin
        m_deb[b] = 1'b0;
        for (int j = 0; j < D + 2; j++) m_smp[b][j] = 1'b0;
      end
      rise_d1 = '0; rise_d2 = '0;
      e_valid = 0; e_pos = 0; e_multi = 0; e_drop = 0; hold_left = 0;
    end else begin
      for (int b = 0; b < 5; b++) begin
        for (int j = D + 1; j > 0; j--) m_smp[b][j] = m_smp[b][j-1];
        m_smp[b][0] = btn_raw[b];
        all_diff = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (m_smp[b][j] == m_deb[b]) all_diff = 1'b0;
        rise_now[b] = 1'b0;
        if (all_diff) begin
          m_deb[b]    = !m_deb[b];
          rise_now[b] = m_deb[b];
        end
      end
      pv      = rise_d2;
      rise_d2 = rise_d1;
      rise_d1 = rise_now;
      e_multi = ($countones(pv) >= 2);
      if (hold_left > 0) begin
        if (pv != 0) e_drop = 1;
        hold_left--;
      end else if (!e_valid) begin
        if (pv != 0) begin
          first = 0;
          for (int b = 4; b >= 0; b--) if (pv[b]) first = b + 1;
          e_valid = 1;
          e_pos   = first;
        end
      end else begin
        if (pv != 0) e_drop = 1;
        if (wif.whack_ready) begin
          e_valid = 0;
          e_pos   = 0;
`ifdef WHACK_HOLDOFF_EN
          hold_left = H;
`endif
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check_val("mon_valid", 32'(wif.whack_valid), 32'(e_valid));
      check_val("mon_pos",   32'(wif.whack_pos),   32'(e_pos));
      check_val("mon_multi", 32'(multi_press),     32'(e_multi));
      check_val("mon_drop",  32'(drop_sticky),     32'(e_drop));
    end
  end

  initial begin
    reset = 1'b1;
    btn_raw = '0;
    wif.whack_ready = 1'b0;
    repeat (3) tick();
    check_val("rst_valid", 32'(wif.whack_valid), 0);
    check_val("rst_pos",   32'(wif.whack_pos),   0);
    check_val("rst_drop",  32'(drop_sticky),     0);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) tick();

    // Latency: held from edge k, valid after edge k+D+3; accept and drop.
    btn_raw[2] = 1'b1;
    repeat (7) tick();
    check_val("lat_early", 32'(wif.whack_valid), 0);
    tick();
    check_val("lat_valid", 32'(wif.whack_valid), 1);
    check_val("lat_pos",   32'(wif.whack_pos),   3);
    repeat (3) tick();
    wif.whack_ready = 1'b1;
    check_val("acc_hold", 32'(wif.whack_valid), 1);
    tick();
    wif.whack_ready = 1'b0;
    check_val("acc_valid", 32'(wif.whack_valid), 0);
    check_val("acc_pos",   32'(wif.whack_pos),   0);
    btn_raw = '0;
    repeat (12) tick();

    // Glitch shorter than D samples is filtered out.
    btn_raw[0] = 1'b1;
    repeat (3) tick();
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val("glitch_valid", 32'(wif.whack_valid), 0);
    end
    check_val("glitch_drop", 32'(drop_sticky), 0);

    // Simultaneous top+middle: top wins, multi_press pulses once.
    btn_raw[1] = 1'b1;
    btn_raw[4] = 1'b1;
    repeat (8) tick();
    check_val("multi_pos",   32'(wif.whack_pos), 2);
    check_val("multi_pulse", 32'(multi_press),   1);
    tick();
    check_val("multi_end",   32'(multi_press),   0);
    wif.whack_ready = 1'b1;
    tick();
    wif.whack_ready = 1'b0;
    btn_raw = '0;
    repeat (12) tick();

    // Second press while pending is discarded and recorded.
    btn_raw[0] = 1'b1;
    repeat (8) tick();
    check_val("pend_pos", 32'(wif.whack_pos), 1);
    btn_raw[3] = 1'b1;
    repeat (10) tick();
    check_val("pend_pos_kept", 32'(wif.whack_pos),   1);
    check_val("pend_drop",     32'(drop_sticky),     1);

    // Asynchronous reset in PEND clears outputs before the next clock edge.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("arst_valid", 32'(wif.whack_valid), 0);
    check_val("arst_pos",   32'(wif.whack_pos),   0);
    check_val("arst_drop",  32'(drop_sticky),     0);
    tick();
    reset = 1'b0;

    // Buttons held through reset must re-debounce before reporting.
    repeat (7) tick();
    check_val("held_early", 32'(wif.whack_valid), 0);
    tick();
    check_val("held_valid", 32'(wif.whack_valid), 1);
    check_val("held_pos",   32'(wif.whack_pos),   1);
    btn_raw = '0;
    repeat (10) tick();

    // Press starting in the acceptance cycle: locked out only with the holdoff.
    wif.whack_ready = 1'b1;
    btn_raw[2] = 1'b1;
    tick();
    wif.whack_ready = 1'b0;
    repeat (8) tick();
`ifdef WHACK_HOLDOFF_EN
    check_val("hold_valid", 32'(wif.whack_valid), 0);
    check_val("hold_drop",  32'(drop_sticky),     1);
`else
    check_val("nohold_valid", 32'(wif.whack_valid), 1);
    check_val("nohold_pos",   32'(wif.whack_pos),   3);
    wif.whack_ready = 1'b1;
    tick();
    wif.whack_ready = 1'b0;
`endif
    btn_raw = '0;
    repeat (12) tick();
    btn_raw[4] = 1'b1;
    repeat (8) tick();
    check_val("after_valid", 32'(wif.whack_valid), 1);
    check_val("after_pos",   32'(wif.whack_pos),   5);
    wif.whack_ready = 1'b1;
    tick();
    wif.whack_ready = 1'b0;
    btn_raw = '0;
    repeat (12) tick();

    // Random button and ready traffic with one reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 11) == 0) btn_raw[b] = ~btn_raw[b];
      wif.whack_ready = ($urandom_range(0, 3) == 0);
      if (c == 2000) reset = 1'b1;
      if (c == 2003) reset = 1'b0;
      tick();
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/whack_encoder.md
WHACK_ENCODER -- requirements
Module: whack_encoder

Interface
REQ-001 SHALL expose parameter: DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (range 2..2^20-1).
REQ-002 SHALL expose parameter: HOLDOFF_CYCLES, 5000000, post-accept lockout length; used only when WHACK_HOLDOFF_EN is defined.
REQ-003 SHALL have port: clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: btn_raw  input  5  unsynchronised buttons: [0] left, [1] top, [2] right, [3] bottom, [4] middle.
REQ-006 SHALL have port: whack_ready  input  1  scorer accepts the pending whack this cycle.
REQ-007 SHALL have port: whack_valid  output  1  a whack event is pending.
REQ-008 SHALL have port: whack_pos  output  3  position code: 1 left, 2 top, 3 right, 4 bottom, 5 middle; 0 when not valid.
REQ-009 SHALL have port: multi_press  output  1  one-cycle pulse when two or more presses are detected in the same cycle.
REQ-010 SHALL have port: drop_sticky  output  1  set when a press is discarded; cleared only by reset.

Function
REQ-011 SHALL pass each btn_raw bit through a two-flop synchroniser before any other use.
REQ-012 SHALL keep, per button, a debounced level and a 20-bit counter; the counter clears whenever the synchronised level equals the debounced level.
REQ-013 SHALL flip the debounced level when the counter reaches DEBOUNCE_CYCLES-1 with the synchronised level still differing; any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
REQ-014 SHALL treat only a 0->1 debounced transition as a press; releases generate no event.
REQ-015 SHALL, for btn_raw held high from before edge k, assert whack_valid at edge k+DEBOUNCE_CYCLES+3.
REQ-016 SHALL resolve same-cycle presses by priority left>top>right>bottom>middle, encode only the winner, and pulse multi_press for exactly one cycle.
REQ-017 SHALL implement FSM IDLE->PEND on a press; PEND->IDLE (or HOLD, see REQ-023) on whack_valid&&whack_ready.
REQ-018 SHALL hold whack_valid and whack_pos stable in PEND until accepted; whack_ready in IDLE is ignored.
REQ-019 SHALL discard presses arriving in PEND (including the acceptance cycle) and set drop_sticky.
REQ-020 SHALL drive whack_pos=0 whenever whack_valid=0.

Reset
REQ-021 SHALL, on reset assertion at any time (including mid-debounce or PEND), force FSM=IDLE, whack_valid=0, whack_pos=0, multi_press=0, drop_sticky=0, all counters=0, synchronisers and debounced levels=0.
REQ-022 SHALL not report a press for a button held through reset release until it debounces high afterwards (DEBOUNCE_CYCLES+3 cycles later).

Configuration
REQ-023 SHALL, with WHACK_HOLDOFF_EN defined, enter HOLD after acceptance for HOLDOFF_CYCLES cycles, discarding presses and setting drop_sticky, then return to IDLE; without it, acceptance returns directly to IDLE with no lockout and HOLDOFF_CYCLES unused.

Verification
REQ-024 SHALL cover: DEBOUNCE_CYCLES=4, btn_raw[2] high from edge 10 -> whack_valid=1, whack_pos=3 at edge 17; whack_ready at edge 20 -> whack_valid=0 at edge 21.
REQ-025 SHALL cover: DEBOUNCE_CYCLES=4, 3-cycle pulse on btn_raw[0] -> whack_valid never asserts, drop_sticky=0.
REQ-026 SHALL cover: btn_raw[1] and btn_raw[4] rise same cycle -> whack_pos=2, multi_press high one cycle.
REQ-027 SHALL cover: whack_ready held 0, second button pressed while PEND -> whack_pos unchanged, drop_sticky=1.
REQ-028 SHALL cover: reset asserted during PEND -> whack_valid=0 and whack_pos=0 immediately (asynchronously), drop_sticky=0.
REQ-029 SHALL cover: WHACK_HOLDOFF_EN with HOLDOFF_CYCLES=8, press accepted, new press debounced within 8 cycles -> no event, drop_sticky=1; press after lockout -> event.
